// File: rtl/cu_defs_pkg.sv
// Shared definitions for control_sequencer: state encodings, opcodes,
// condition-select codes, instruction field positions and the control word.
package cu_defs;

  localparam int PC_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ALU  = 3'd1,
    OP_ALUI = 3'd2,
    OP_LD   = 3'd3,
    OP_ST   = 3'd4,
    OP_BR   = 3'd5,
    OP_JMP  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  localparam logic [1:0] CS_Z = 2'd0;
  localparam logic [1:0] CS_N = 2'd1;
  localparam logic [1:0] CS_C = 2'd2;
  localparam logic [1:0] CS_V = 2'd3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int FS_MSB  = 12;
  localparam int FS_LSB  = 9;
  localparam int DR_MSB  = 8;
  localparam int DR_LSB  = 6;
  localparam int SA_MSB  = 5;
  localparam int SA_LSB  = 3;
  localparam int SB_MSB  = 2;
  localparam int SB_LSB  = 0;
  localparam int BR_INV  = 12;
  localparam int CS_MSB  = 10;
  localparam int CS_LSB  = 9;

  typedef struct packed {
    logic [3:0] fs;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       mb;
    logic [7:0] kconst;
    logic       md;
    logic       rw;
    logic       dmem_we;
  } ctrl_t;

  // Status register layout is {v, c, n, z}.
  function automatic logic br_cond(input logic [3:0] sr, input logic [1:0] sel, input logic inv);
    logic f;
    case (sel)
      CS_Z:    f = sr[0];
      CS_N:    f = sr[1];
      CS_C:    f = sr[2];
      CS_V:    f = sr[3];
      default: f = 1'b0;
    endcase
    return f ^ inv;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of the instruction register and sequencer state into
// the datapath control word; everything is zero outside EXEC and MEM.
module cu_decode
  import cu_defs::*;
(
  input  logic [15:0] i_ir,
  input  state_t      i_state,
  input  logic        i_dmem_ack,
  output ctrl_t       o_ctrl
);

  opcode_t w_op;
  logic    w_active;

  assign w_op     = opcode_t'(i_ir[OP_MSB:OP_LSB]);
  assign w_active = (i_state == ST_EXEC) || (i_state == ST_MEM);

  always_comb begin
    o_ctrl = '0;
    if (w_active) begin
      o_ctrl.fs     = i_ir[FS_MSB:FS_LSB];
      o_ctrl.da     = i_ir[DR_MSB:DR_LSB];
      o_ctrl.aa     = i_ir[SA_MSB:SA_LSB];
      o_ctrl.ba     = i_ir[SB_MSB:SB_LSB];
      o_ctrl.kconst = {5'b00000, i_ir[SB_MSB:SB_LSB]};
      if (i_state == ST_EXEC) begin
        case (w_op)
          OP_ALU:  o_ctrl.rw = 1'b1;
          OP_ALUI: begin
            o_ctrl.rw = 1'b1;
            o_ctrl.mb = 1'b1;
          end
          default: o_ctrl.rw = 1'b0;
        endcase
      end else begin
        // Load write-back only fires in the cycle memory acknowledges.
        case (w_op)
          OP_LD: begin
            o_ctrl.rw = i_dmem_ack;
            o_ctrl.md = i_dmem_ack;
          end
          OP_ST:   o_ctrl.dmem_we = 1'b1;
          default: o_ctrl.dmem_we = 1'b0;
        endcase
      end
    end else begin
      o_ctrl = '0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath.
// Conditional branches and the status register exist only with CU_COND_BRANCH_EN.
module control_sequencer
  import cu_defs::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [3:0]      fs,
  output logic [2:0]      da,
  output logic [2:0]      aa,
  output logic [2:0]      ba,
  output logic            mb,
  output logic [7:0]      kconst,
  output logic            md,
  output logic            rw,
  input  logic            v,
  input  logic            c,
  input  logic            n,
  input  logic            z,
  input  logic [7:0]      a_data,
  output logic            halted
);

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_pc_br;
  logic [15:0]     r_ir, w_ir_nxt;
  logic [5:0]      w_off;
  opcode_t         w_op;
  ctrl_t           w_ctrl;
  logic            w_br_taken;

  assign w_op     = opcode_t'(r_ir[OP_MSB:OP_LSB]);
  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_off    = {r_ir[DR_MSB:DR_LSB], r_ir[SB_MSB:SB_LSB]};
  assign w_pc_br  = w_pc_inc + PC_W'(signed'(w_off));

`ifdef CU_COND_BRANCH_EN
  logic [3:0] r_sr, w_sr_nxt;

  // Status register captures the flags only when an ALU/ALUI executes.
  always_comb begin
    w_sr_nxt = r_sr;
    if ((r_state == ST_EXEC) && ((w_op == OP_ALU) || (w_op == OP_ALUI))) begin
      w_sr_nxt = {v, c, n, z};
    end else begin
      w_sr_nxt = r_sr;
    end
  end

  assign w_br_taken = br_cond(r_sr, r_ir[CS_MSB:CS_LSB], r_ir[BR_INV]);

  // Status register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr <= 4'b0000;
    end else begin
      r_sr <= w_sr_nxt;
    end
  end
`else
  logic w_unused_flags;
  assign w_unused_flags = ^{v, c, n, z};
  assign w_br_taken     = 1'b0;
`endif

  // Next-state, PC and IR update.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_EXEC: begin
        case (w_op)
          OP_LD, OP_ST: w_state_nxt = ST_MEM;
          OP_HALT: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_HALT;
          end
          OP_JMP: begin
            w_pc_nxt    = PC_W'(a_data);
            w_state_nxt = ST_FETCH;
          end
          OP_BR: begin
            w_pc_nxt    = w_br_taken ? w_pc_br : w_pc_inc;
            w_state_nxt = ST_FETCH;
          end
          default: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_MEM;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  cu_decode u_decode (
    .i_ir       (r_ir),
    .i_state    (r_state),
    .i_dmem_ack (dmem_ack),
    .o_ctrl     (w_ctrl)
  );

  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign dmem_req  = (r_state == ST_MEM);
  assign halted    = (r_state == ST_HALT);
  assign dmem_we   = w_ctrl.dmem_we;
  assign fs        = w_ctrl.fs;
  assign da        = w_ctrl.da;
  assign aa        = w_ctrl.aa;
  assign ba        = w_ctrl.ba;
  assign mb        = w_ctrl.mb;
  assign kconst    = w_ctrl.kconst;
  assign md        = w_ctrl.md;
  assign rw        = w_ctrl.rw;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle instruction control unit for the 8-bit datapath. Fetches 16-bit instructions over a request/acknowledge port, decodes them, and drives the function-unit select code, register-file addresses and load/write enables. Consumes the V/C/N/Z flags for conditional branches and sequences loads and stores through a data-memory handshake. Sits between instruction memory and the register file / function unit / data memory.

## Interface
- PC_W, 8, program counter and instruction address width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ack  in  1  data access complete
- fs  out  4  function-select code to function unit
- da / aa / ba  out  3 each  destination / A / B register addresses
- mb  out  1  B operand source: 0 register, 1 constant
- kconst  out  8  zero-extended constant
- md  out  1  write-back source: 0 function unit, 1 memory
- rw  out  1  register-file write enable
- v, c, n, z  in  1 each  function-unit flags
- a_data  in  8  register A value (jump target)
- halted  out  1  processor halted

## Operation
- Instruction: op[15:13], fs[12:9], DR[8:6], SA[5:3], SB[2:0]; da=DR, aa=SA, ba=SB, kconst={5'b0,SB}.
- Opcodes: 000 NOP; 001 ALU (fs=ir[12:9], mb=0, rw=1); 010 ALUI (mb=1, rw=1); 011 LD (md=1, rw on dmem_ack); 100 ST (dmem_we=1, address from A, data from B); 101 BR; 110 JMP (PC ← a_data[PC_W-1:0]); 111 HALT.
- States: IDLE → FETCH → EXEC → FETCH; EXEC → MEM for LD/ST; EXEC → HALT for HALT; HALT absorbing until reset.
- IDLE: single cycle after reset, all outputs 0.
- FETCH: imem_req=1 until imem_ack; IR ← imem_rdata on ack; next EXEC.
- EXEC: one cycle; ALU/ALUI assert rw, latch {v,c,n,z} into status register SR; PC ← PC+1 except taken BR / JMP.
- MEM: dmem_req=1 held until dmem_ack; LD asserts rw and md only in the ack cycle; PC ← PC+1 on ack.
- BR: flag selected by ir[10:9] (00 Z, 01 N, 10 C, 11 V) from SR, inverted if ir[12]; taken → PC ← PC+1+sext({DR,SB}) modulo 2^PC_W.
- rw, dmem_req, imem_req never asserted outside the states listed; fs/da/aa/ba driven from IR in EXEC and MEM, 0 otherwise.

## Timing
- Reset: PC=0, IR=0, SR=0, state IDLE, every output 0, halted=0.
- imem_req asserted in first cycle after IDLE; zero-wait ack gives 2-cycle ALU instruction (FETCH+EXEC), 3-cycle LD/ST (FETCH+EXEC+MEM).
- Requests held stable (address, we) until ack; ack without request ignored.
- Flags from ALU in EXEC cycle N visible to BR executed in any later instruction; SR unchanged by NOP/LD/ST/BR/JMP.
- PC wraps 0xFF→0x00 (PC_W=8) on increment and branch.
- rst_n low in any state (including mid-request): next cycle IDLE, requests dropped, pending ack discarded.
- HALT: halted=1 from cycle after EXEC of HALT; no further requests.

## Configuration
- CU_COND_BRANCH_EN defined: BR as above, SR implemented.
- Undefined: opcode 101 executes as NOP (PC+1), SR absent, v/c/n/z unused.

## Structure
- Shared package cu_defs: state encodings, opcode constants, condition-select codes, instruction field positions, PC_W default.
- Sub-module cu_decode: combinational IR + state → control word (fs, addresses, mb, md, rw, dmem_we, kconst).

## Test plan
- Reset then instruction 0x2000+ALU (0x2A53, op 001 fs 0101 DR1 SA2 SB3), zero-wait ack → imem_req cycle 1, rw=1 da=1 aa=2 ba=3 fs=5 cycle 2, imem_addr=1 cycle 3.
- LD 0x6088 with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, rw/md pulse only in ack cycle, PC advances once.
- ALU producing z=1 then BR Z offset −2 at PC 0x05 → PC=0x04; same with ir[12]=1 → PC=0x06; without CU_COND_BRANCH_EN → PC=0x06.
- PC=0xFF executes NOP → next imem_addr=0x00.
- rst_n low while imem_req waits; ack arrives during reset → ignored, IDLE then fetch at address 0.
- HALT 0xE000 → halted=1, no imem_req for 20 cycles.
